// File: rtl/writeback_unit_pkg.sv
// rtl/writeback_unit_pkg.sv - shared types and constants for the writeback stage
package writeback_unit_pkg;

   // Kind of retire request arriving from the previous stage
   typedef enum logic [1:0] {
      WB_NONE = 2'd0,
      WB_ALU  = 2'd1,
      WB_LOAD = 2'd2
   } wb_kind_t;

   // Load width/sign encodings carried in funct3
   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_WAIT_MEM = 1'b1
   } wb_state_t;

endpackage

// File: rtl/writeback_unit_if.sv
// rtl/writeback_unit_if.sv - retire request and data-memory response bundle
interface writeback_unit_if #(
   parameter int XLEN = 32
) ();
   logic            i_valid;
   logic [1:0]      i_kind;
   logic [4:0]      i_rd;
   logic [XLEN-1:0] i_result;
   logic [2:0]      i_funct3;
   logic            o_ready;
   logic            i_mem_rvalid;
   logic [XLEN-1:0] i_mem_rdata;

   modport master (
      output i_valid, i_kind, i_rd, i_result, i_funct3, i_mem_rvalid, i_mem_rdata,
      input  o_ready
   );

   modport slave (
      input  i_valid, i_kind, i_rd, i_result, i_funct3, i_mem_rvalid, i_mem_rdata,
      output o_ready
   );
endinterface

// File: rtl/writeback_unit_load_align.sv
// rtl/writeback_unit_load_align.sv - lane extraction and sign/zero extension of load data
module load_align
   import writeback_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] i_rdata,
   input  logic [1:0]      i_addr,
   input  logic [2:0]      i_funct3,
   output logic [XLEN-1:0] o_value,
   output logic            o_misaligned,
   output logic            o_illegal
);
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_rdata[{i_addr, 3'b000} +: 8];
   assign w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

   // Select lane by width, extend by sign flavour, flag bad alignment or encoding
   always_comb begin
      o_value      = i_rdata;
      o_misaligned = 1'b0;
      o_illegal    = 1'b0;
      case (i_funct3)
         F3_LB:  o_value = {{(XLEN-8){w_byte[7]}}, w_byte};
         F3_LBU: o_value = {{(XLEN-8){1'b0}}, w_byte};
         F3_LH: begin
            o_value      = {{(XLEN-16){w_half[15]}}, w_half};
            o_misaligned = i_addr[0];
         end
         F3_LHU: begin
            o_value      = {{(XLEN-16){1'b0}}, w_half};
            o_misaligned = i_addr[0];
         end
         F3_LW: begin
            o_value      = i_rdata;
            o_misaligned = |i_addr;
         end
         default: o_illegal = 1'b1;
      endcase
   end
endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - register-file writeback stage with load wait, hold buffer and watchdog
module writeback_unit
   import writeback_unit_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   writeback_unit_if.slave  req_if,
   output logic             o_wback,
   output logic [4:0]       o_wreg,
   output logic [XLEN-1:0]  o_wdata,
   output logic             o_fault,
   output logic [CNT_W-1:0] o_retired
);
   // Watchdog fires on the cycle its count would reach TIMEOUT
   localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT - 1);

   wb_state_t        r_state, w_state_nx;
   logic [31:0]      r_wdog, w_wdog_nx;
   logic             r_wback, w_wback_nx;
   logic             r_fault, w_fault_nx;
   logic [4:0]       r_wreg, w_wreg_nx;
   logic [XLEN-1:0]  r_wdata, w_wdata_nx;
   logic [CNT_W-1:0] r_retired;
   logic             w_retire;

   logic             r_buf_vld, w_buf_vld_nx;
   logic             r_buf_wr, w_buf_wr_nx;
   logic [4:0]       r_buf_rd, w_buf_rd_nx;
   logic [XLEN-1:0]  r_buf_data, w_buf_data_nx;

   logic [4:0]       r_ld_rd, w_ld_rd_nx;
   logic [1:0]       r_ld_lane, w_ld_lane_nx;
   logic [2:0]       r_ld_f3, w_ld_f3_nx;

   logic [XLEN-1:0]  w_ld_value;
   logic             w_ld_misaligned;
   logic             w_ld_illegal;

   load_align #(.XLEN(XLEN)) u_align (
      .i_rdata      (req_if.i_mem_rdata),
      .i_addr       (r_ld_lane),
      .i_funct3     (r_ld_f3),
      .o_value      (w_ld_value),
      .o_misaligned (w_ld_misaligned),
      .o_illegal    (w_ld_illegal)
   );

   // A held ALU result blocks new requests for the one cycle it owns the write port
   assign req_if.o_ready = ((r_state == ST_IDLE) && !r_buf_vld) ||
                           ((r_state == ST_WAIT_MEM) && req_if.i_mem_rvalid);

   assign o_wback   = r_wback;
   assign o_wreg    = r_wreg;
   assign o_wdata   = r_wdata;
   assign o_fault   = r_fault;
   assign o_retired = r_retired;

   // Next-state, write-port and buffer decisions for the coming cycle
   always_comb begin
      w_state_nx    = r_state;
      w_wdog_nx     = r_wdog;
      w_wback_nx    = 1'b0;
      w_fault_nx    = 1'b0;
      w_wreg_nx     = r_wreg;
      w_wdata_nx    = r_wdata;
      w_retire      = 1'b0;
      w_buf_vld_nx  = 1'b0;
      w_buf_wr_nx   = r_buf_wr;
      w_buf_rd_nx   = r_buf_rd;
      w_buf_data_nx = r_buf_data;
      w_ld_rd_nx    = r_ld_rd;
      w_ld_lane_nx  = r_ld_lane;
      w_ld_f3_nx    = r_ld_f3;
      case (r_state)
         ST_IDLE: begin
            if (r_buf_vld) begin
               w_retire = 1'b1;
               if (r_buf_wr && (r_buf_rd != 5'd0)) begin
                  w_wback_nx = 1'b1;
                  w_wreg_nx  = r_buf_rd;
                  w_wdata_nx = r_buf_data;
               end
            end else if (req_if.i_valid) begin
               if (req_if.i_kind == WB_LOAD) begin
                  w_state_nx   = ST_WAIT_MEM;
                  w_wdog_nx    = 32'd0;
                  w_ld_rd_nx   = req_if.i_rd;
                  w_ld_lane_nx = req_if.i_result[1:0];
                  w_ld_f3_nx   = req_if.i_funct3;
               end else begin
                  w_retire = 1'b1;
                  if ((req_if.i_kind == WB_ALU) && (req_if.i_rd != 5'd0)) begin
                     w_wback_nx = 1'b1;
                     w_wreg_nx  = req_if.i_rd;
                     w_wdata_nx = req_if.i_result;
                  end
               end
            end
         end
         ST_WAIT_MEM: begin
            if (req_if.i_mem_rvalid) begin
               w_retire   = 1'b1;
               w_state_nx = ST_IDLE;
               if (w_ld_misaligned || w_ld_illegal) begin
                  w_fault_nx = 1'b1;
               end else if (r_ld_rd != 5'd0) begin
                  w_wback_nx = 1'b1;
                  w_wreg_nx  = r_ld_rd;
                  w_wdata_nx = w_ld_value;
               end
               if (req_if.i_valid) begin
                  if (req_if.i_kind == WB_LOAD) begin
                     w_state_nx   = ST_WAIT_MEM;
                     w_wdog_nx    = 32'd0;
                     w_ld_rd_nx   = req_if.i_rd;
                     w_ld_lane_nx = req_if.i_result[1:0];
                     w_ld_f3_nx   = req_if.i_funct3;
                  end else begin
                     w_buf_vld_nx  = 1'b1;
                     w_buf_wr_nx   = (req_if.i_kind == WB_ALU);
                     w_buf_rd_nx   = req_if.i_rd;
                     w_buf_data_nx = req_if.i_result;
                  end
               end
            end else if ((TIMEOUT != 0) && (r_wdog == WDOG_LAST)) begin
               w_retire   = 1'b1;
               w_fault_nx = 1'b1;
               w_state_nx = ST_IDLE;
            end else begin
               w_wdog_nx = r_wdog + 32'd1;
            end
         end
         default: w_state_nx = ST_IDLE;
      endcase
   end

   // Control state and output registers, cleared by reset from any state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_wdog    <= 32'd0;
         r_buf_vld <= 1'b0;
         r_wback   <= 1'b0;
         r_fault   <= 1'b0;
         r_wreg    <= 5'd0;
         r_wdata   <= '0;
         r_retired <= '0;
      end else begin
         r_state   <= w_state_nx;
         r_wdog    <= w_wdog_nx;
         r_buf_vld <= w_buf_vld_nx;
         r_wback   <= w_wback_nx;
         r_fault   <= w_fault_nx;
         r_wreg    <= w_wreg_nx;
         r_wdata   <= w_wdata_nx;
         if (w_retire) r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Payload of the pending load and the held ALU request; only read when marked valid
   always_ff @(posedge clk) begin
      r_buf_wr   <= w_buf_wr_nx;
      r_buf_rd   <= w_buf_rd_nx;
      r_buf_data <= w_buf_data_nx;
      r_ld_rd    <= w_ld_rd_nx;
      r_ld_lane  <= w_ld_lane_nx;
      r_ld_f3    <= w_ld_f3_nx;
   end
endmodule
